// File: rtl/ehl_timer_pkg.sv
// ---------------------------------------------------------------------------
// ehl_timer_pkg
// Shared encodings for the timer counting engine:
//   - tmr_mode values (periodic, compare-stop, PWM)
//   - cpt_type values (rise, fall, both, off)
//   - small decode helpers used by ehl_timer_core
// ---------------------------------------------------------------------------
package ehl_timer_pkg;

   localparam logic [2:0] TMR_MODE_PERIODIC = 3'b000;
   localparam logic [2:0] TMR_MODE_CMP      = 3'b001;
   localparam logic [2:0] TMR_MODE_PWM      = 3'b010;

   localparam logic [1:0] CPT_RISE = 2'b00;
   localparam logic [1:0] CPT_FALL = 2'b01;
   localparam logic [1:0] CPT_BOTH = 2'b10;
   localparam logic [1:0] CPT_OFF  = 2'b11;

   // Modes in which the counter parks on its terminal value after expiry.
   function automatic logic tmr_hold_mode(input logic [2:0] mode);
      logic hold;
      case (mode)
         TMR_MODE_PERIODIC: hold = 1'b0;
         TMR_MODE_CMP:      hold = 1'b1;
         TMR_MODE_PWM:      hold = 1'b0;
         default:           hold = 1'b0;
      endcase
      return hold;
   endfunction

   // Selects which synchronised pin edge(s) trigger a capture.
   function automatic logic cpt_hit(input logic [1:0] sel,
                                    input logic       rise,
                                    input logic       fall);
      logic hit;
      case (sel)
         CPT_RISE: hit = rise;
         CPT_FALL: hit = fall;
         CPT_BOTH: hit = rise | fall;
         CPT_OFF:  hit = 1'b0;
         default:  hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/ehl_timer_if.sv
// ---------------------------------------------------------------------------
// ehl_timer_if
// Configuration/status bundle between the timer CSR block (master) and the
// counting engine ehl_timer_core (slave).
//   master drives : ena, pause, dir, oneshot, tmr_mode, tmr_pre, tmr_load,
//                   tmr_dead, cmp_en, cmp{a,b,c}_t{0,1}, pwm_comp, cpt_type,
//                   cpt_in
//   slave drives  : tmr_val, tmr_cpt, stop_tmr, evt_cmp, evt_cpt, pwm_out,
//                   pwm_out_n
// ---------------------------------------------------------------------------
interface ehl_timer_if #(
   parameter int TIMER_WIDTH = 32
);
   logic                   ena;
   logic                   pause;
   logic                   dir;
   logic                   oneshot;
   logic [2:0]             tmr_mode;
   logic [7:0]             tmr_pre;
   logic [TIMER_WIDTH-1:0] tmr_load;
   logic [TIMER_WIDTH-1:0] tmr_dead;
   logic [2:0]             cmp_en;
   logic [TIMER_WIDTH-1:0] cmpa_t0;
   logic [TIMER_WIDTH-1:0] cmpa_t1;
   logic [TIMER_WIDTH-1:0] cmpb_t0;
   logic [TIMER_WIDTH-1:0] cmpb_t1;
   logic [TIMER_WIDTH-1:0] cmpc_t0;
   logic [TIMER_WIDTH-1:0] cmpc_t1;
   logic                   pwm_comp;
   logic [1:0]             cpt_type;
   logic                   cpt_in;
   logic [TIMER_WIDTH-1:0] tmr_val;
   logic [TIMER_WIDTH-1:0] tmr_cpt;
   logic                   stop_tmr;
   logic [2:0]             evt_cmp;
   logic                   evt_cpt;
   logic [2:0]             pwm_out;
   logic [2:0]             pwm_out_n;

   modport master (
      output ena, pause, dir, oneshot, tmr_mode, tmr_pre, tmr_load, tmr_dead,
             cmp_en, cmpa_t0, cmpa_t1, cmpb_t0, cmpb_t1, cmpc_t0, cmpc_t1,
             pwm_comp, cpt_type, cpt_in,
      input  tmr_val, tmr_cpt, stop_tmr, evt_cmp, evt_cpt, pwm_out, pwm_out_n
   );

   modport slave (
      input  ena, pause, dir, oneshot, tmr_mode, tmr_pre, tmr_load, tmr_dead,
             cmp_en, cmpa_t0, cmpa_t1, cmpb_t0, cmpb_t1, cmpc_t0, cmpc_t1,
             pwm_comp, cpt_type, cpt_in,
      output tmr_val, tmr_cpt, stop_tmr, evt_cmp, evt_cpt, pwm_out, pwm_out_n
   );
endinterface

// File: rtl/ehl_timer_pwm_ch.sv
// ---------------------------------------------------------------------------
// ehl_timer_pwm_ch
// One compare/PWM channel: set/clear compare on the post-update count, raw
// output flop, registered complement and optional dead-time insertion.
// Build option: EHL_TIMER_DEADTIME_EN inserts i_dead clk cycles of both-low
// before every rising edge of o_pwm / o_pwm_n; otherwise i_dead is ignored.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   i_en        channel enable (cmp_en[k]); 0 forces raw low
//   i_tick      counter advanced this cycle
//   i_cnt_nxt   counter value being written on this tick
//   i_t0/i_t1   set / clear points (clear wins on equality)
//   i_dead      dead-time length in clk cycles
//   i_comp      drive the complementary output
//   o_pwm       channel output
//   o_pwm_n     complementary output
//   o_evt       1-cycle compare-match pulse
// ---------------------------------------------------------------------------
module ehl_timer_pwm_ch #(
   parameter int TIMER_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_en,
   input  logic                   i_tick,
   input  logic [TIMER_WIDTH-1:0] i_cnt_nxt,
   input  logic [TIMER_WIDTH-1:0] i_t0,
   input  logic [TIMER_WIDTH-1:0] i_t1,
   input  logic [TIMER_WIDTH-1:0] i_dead,
   input  logic                   i_comp,
   output logic                   o_pwm,
   output logic                   o_pwm_n,
   output logic                   o_evt
);

   logic w_hit0;
   logic w_hit1;
   logic w_raw_nxt;
   logic r_raw;
   logic r_raw_n;
   logic r_evt;

   assign w_hit0 = i_tick & (i_cnt_nxt == i_t0);
   assign w_hit1 = i_tick & (i_cnt_nxt == i_t1);

   always_comb begin
      w_raw_nxt = r_raw;
      if (!i_en)       w_raw_nxt = 1'b0;
      else if (w_hit1) w_raw_nxt = 1'b0;
      else if (w_hit0) w_raw_nxt = 1'b1;
   end

   // The complement is registered from the same next value so both outputs
   // change on the same edge and both read 0 straight out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_raw   <= 1'b0;
         r_raw_n <= 1'b0;
         r_evt   <= 1'b0;
      end else begin
         r_raw   <= w_raw_nxt;
         r_raw_n <= i_comp & ~w_raw_nxt;
         r_evt   <= i_en & (w_hit0 | w_hit1);
      end
   end

   assign o_evt = r_evt;

`ifdef EHL_TIMER_DEADTIME_EN
   logic                   r_raw_d;
   logic                   r_raw_n_d;
   logic [TIMER_WIDTH-1:0] r_dt;
   logic                   w_edge;
   logic                   w_gap;

   // Any transition of either output (re)starts the gap. The edge cycle is
   // itself the first gap cycle, hence the counter is loaded with i_dead-1.
   assign w_edge = (r_raw != r_raw_d) | (r_raw_n != r_raw_n_d);
   assign w_gap  = (w_edge & (i_dead != '0)) | (r_dt != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_raw_d   <= 1'b0;
         r_raw_n_d <= 1'b0;
         r_dt      <= '0;
      end else begin
         r_raw_d   <= r_raw;
         r_raw_n_d <= r_raw_n;
         if (w_edge)
            r_dt <= (i_dead != '0) ? i_dead - TIMER_WIDTH'(1) : '0;
         else if (r_dt != '0)
            r_dt <= r_dt - TIMER_WIDTH'(1);
      end
   end

   // Masking only ever removes highs, so falling edges stay immediate.
   assign o_pwm   = r_raw   & ~w_gap;
   assign o_pwm_n = r_raw_n & ~w_gap;
`else
   logic w_unused_dead;
   assign w_unused_dead = ^i_dead;

   assign o_pwm   = r_raw;
   assign o_pwm_n = r_raw_n;
`endif

endmodule

// File: rtl/ehl_timer_core.sv
// ---------------------------------------------------------------------------
// ehl_timer_core
// Counting engine behind the timer CSR block: 8-bit prescaler, up/down
// counter with load/reload and one-shot hold, three compare/PWM channels
// (ehl_timer_pwm_ch) and an edge-capture unit.
// Build option: EHL_TIMER_DEADTIME_EN (inside ehl_timer_pwm_ch) enables
// dead-time insertion on the PWM outputs.
// Parameters:
//   TIMER_WIDTH  counter/compare width (8..32, multiple of 8)
//   PWM_ENA      drive pwm_out / pwm_out_n (else tied 0)
//   CMP_ENA      drive evt_cmp (else tied 0)
//   CPT_ENA      build the capture unit (else tmr_cpt / evt_cpt tied 0)
// Ports:
//   clk    timer clock
//   reset  synchronous, active-high reset
//   bus    ehl_timer_if.slave: configuration in, tmr_val / tmr_cpt /
//          stop_tmr / evt_cmp / evt_cpt / pwm_out / pwm_out_n out
// ---------------------------------------------------------------------------
module ehl_timer_core
   import ehl_timer_pkg::*;
#(
   parameter int TIMER_WIDTH = 32,
   parameter int PWM_ENA     = 0,
   parameter int CMP_ENA     = 0,
   parameter int CPT_ENA     = 0
) (
   input  logic           clk,
   input  logic           reset,
   ehl_timer_if.slave     bus
);

   localparam int TW = TIMER_WIDTH;

   logic          r_ena_d;
   logic [7:0]    r_pre;
   logic [7:0]    w_pre_nxt;
   logic [TW-1:0] r_cnt;
   logic [TW-1:0] w_cnt_nxt;
   logic [TW-1:0] r_term;
   logic [TW-1:0] w_term_nxt;
   logic [TW-1:0] r_val;
   logic          r_stop;
   logic          w_start;
   logic          w_tick;
   logic          w_expire;
   logic          w_hold;

   logic [TW-1:0] w_t0 [3];
   logic [TW-1:0] w_t1 [3];
   logic [2:0]    w_pwm;
   logic [2:0]    w_pwm_n;
   logic [2:0]    w_evt;

   // Start is the first cycle ena is seen high; it loads and never ticks.
   assign w_start = bus.ena & ~r_ena_d;
   assign w_tick  = bus.ena & ~bus.pause & ~w_start & (r_pre == bus.tmr_pre);
   assign w_hold  = bus.oneshot | tmr_hold_mode(bus.tmr_mode);

   // Up counting terminates on r_term, latched at start/reload, so a
   // tmr_load written mid-period does not move the current terminal value.
   assign w_expire = w_tick & (bus.dir ? (r_cnt == r_term) : (r_cnt == '0));

   always_comb begin
      w_pre_nxt = r_pre + 8'd1;
      if (!bus.ena || w_start || w_tick) w_pre_nxt = 8'd0;
      else if (bus.pause)                w_pre_nxt = r_pre;
   end

   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_term_nxt = r_term;
      if (w_start) begin
         w_cnt_nxt  = bus.dir ? '0 : bus.tmr_load;
         w_term_nxt = bus.tmr_load;
      end else if (w_expire) begin
         if (!w_hold) begin
            w_cnt_nxt  = bus.dir ? '0 : bus.tmr_load;
            w_term_nxt = bus.tmr_load;
         end
      end else if (w_tick) begin
         w_cnt_nxt = bus.dir ? r_cnt + TW'(1) : r_cnt - TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ena_d <= 1'b0;
         r_pre   <= 8'd0;
         r_cnt   <= '0;
         r_term  <= '0;
         r_val   <= '0;
         r_stop  <= 1'b0;
      end else begin
         r_ena_d <= bus.ena;
         r_pre   <= w_pre_nxt;
         r_cnt   <= w_cnt_nxt;
         r_term  <= w_term_nxt;
         r_val   <= r_cnt;
         r_stop  <= w_expire;
      end
   end

   assign bus.tmr_val  = r_val;
   assign bus.stop_tmr = r_stop;

   // ---- compare / PWM channels -------------------------------------------
   assign w_t0[0] = bus.cmpa_t0;
   assign w_t1[0] = bus.cmpa_t1;
   assign w_t0[1] = bus.cmpb_t0;
   assign w_t1[1] = bus.cmpb_t1;
   assign w_t0[2] = bus.cmpc_t0;
   assign w_t1[2] = bus.cmpc_t1;

   for (genvar k = 0; k < 3; k++) begin : g_ch
      ehl_timer_pwm_ch #(.TIMER_WIDTH(TW)) u_ch (
         .clk       (clk),
         .reset     (reset),
         .i_en      (bus.cmp_en[k]),
         .i_tick    (w_tick),
         .i_cnt_nxt (w_cnt_nxt),
         .i_t0      (w_t0[k]),
         .i_t1      (w_t1[k]),
         .i_dead    (bus.tmr_dead),
         .i_comp    (bus.pwm_comp),
         .o_pwm     (w_pwm[k]),
         .o_pwm_n   (w_pwm_n[k]),
         .o_evt     (w_evt[k])
      );
   end

   assign bus.pwm_out   = (PWM_ENA != 0) ? w_pwm   : 3'b000;
   assign bus.pwm_out_n = (PWM_ENA != 0) ? w_pwm_n : 3'b000;
   assign bus.evt_cmp   = (CMP_ENA != 0) ? w_evt   : 3'b000;

   // ---- capture unit -----------------------------------------------------
   if (CPT_ENA != 0) begin : g_cpt
      // [0],[1] synchroniser, [2] previous synchronised value for edge detect.
      logic [2:0]    r_sync;
      logic [TW-1:0] r_cpt;
      logic          r_evt_cpt;
      logic          w_rise;
      logic          w_fall;
      logic          w_hit;

      assign w_rise = r_sync[1] & ~r_sync[2];
      assign w_fall = ~r_sync[1] & r_sync[2];
      assign w_hit  = cpt_hit(bus.cpt_type, w_rise, w_fall);

      // Not gated by ena/pause: capture keeps working on a stopped counter.
      always_ff @(posedge clk) begin
         if (reset) begin
            r_sync    <= 3'b000;
            r_cpt     <= '0;
            r_evt_cpt <= 1'b0;
         end else begin
            r_sync    <= {r_sync[1:0], bus.cpt_in};
            r_evt_cpt <= w_hit;
            if (w_hit) r_cpt <= r_cnt;
         end
      end

      assign bus.tmr_cpt = r_cpt;
      assign bus.evt_cpt = r_evt_cpt;
   end else begin : g_no_cpt
      logic w_unused_cpt;
      assign w_unused_cpt = ^{bus.cpt_in, bus.cpt_type};
      assign bus.tmr_cpt  = '0;
      assign bus.evt_cpt  = 1'b0;
   end

endmodule

// File: tb/tb_ehl_timer_core.sv
// ---------------------------------------------------------------------------
// tb_ehl_timer_core
// Self-checking bench for ehl_timer_core (all features enabled, 16-bit).
// Expected per-cycle values are derived from closed-form timing formulas,
// queued before stimulus starts and popped as the DUT produces each cycle.
// ---------------------------------------------------------------------------
module tb_ehl_timer_core;
   import ehl_timer_pkg::*;

   localparam int TW = 16;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   ehl_timer_if #(.TIMER_WIDTH(TW)) tif ();

   ehl_timer_core #(
      .TIMER_WIDTH (TW),
      .PWM_ENA     (1),
      .CMP_ENA     (1),
      .CPT_ENA     (1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (tif)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [TW-1:0] val;
      logic          stop;
   } cnt_exp_t;

   typedef struct {
      logic [TW-1:0] val;
      logic [2:0]    pwm;
      logic [2:0]    pwm_n;
      logic [2:0]    evt;
   } pwm_exp_t;

   cnt_exp_t      cq[$];
   pwm_exp_t      pq[$];
   logic [TW-1:0] capq[$];

`ifdef EHL_TIMER_DEADTIME_EN
   localparam bit DT = 1'b1;
`else
   localparam bit DT = 1'b0;
`endif

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_idle();
      tif.ena = 0; tif.pause = 0; tif.dir = 0; tif.oneshot = 0;
      tif.tmr_mode = TMR_MODE_PERIODIC; tif.tmr_pre = 0;
      tif.tmr_load = 0; tif.tmr_dead = 0; tif.cmp_en = 0;
      tif.cmpa_t0 = 0; tif.cmpa_t1 = 0; tif.cmpb_t0 = 0; tif.cmpb_t1 = 0;
      tif.cmpc_t0 = 0; tif.cmpc_t1 = 0; tif.pwm_comp = 0;
      tif.cpt_type = CPT_RISE; tif.cpt_in = 0;
   endtask

   task automatic do_reset();
      cfg_idle();
      reset = 1;
      step();
      step();
      reset = 0;
   endtask

   task automatic test_reset();
      cfg_idle();
      reset = 1;
      repeat (3) step();
      n_checks++; if (tif.tmr_val !== '0) begin n_fail++; $display("FAIL reset_tmr_val: got %0d want 0", tif.tmr_val); end
      n_checks++; if (tif.tmr_cpt !== '0) begin n_fail++; $display("FAIL reset_tmr_cpt: got %0d want 0", tif.tmr_cpt); end
      n_checks++; if (tif.stop_tmr !== 1'b0) begin n_fail++; $display("FAIL reset_stop_tmr: got %b want 0", tif.stop_tmr); end
      n_checks++; if (tif.evt_cmp !== 3'b000) begin n_fail++; $display("FAIL reset_evt_cmp: got %b want 000", tif.evt_cmp); end
      n_checks++; if (tif.evt_cpt !== 1'b0) begin n_fail++; $display("FAIL reset_evt_cpt: got %b want 0", tif.evt_cpt); end
      n_checks++; if (tif.pwm_out !== 3'b000) begin n_fail++; $display("FAIL reset_pwm_out: got %b want 000", tif.pwm_out); end
      n_checks++; if (tif.pwm_out_n !== 3'b000) begin n_fail++; $display("FAIL reset_pwm_out_n: got %b want 000", tif.pwm_out_n); end
      reset = 0;
   endtask

   // Down, load 3, every clock: 3,2,1,0,3,... with stop on every 4th tick.
   task automatic test_periodic_down();
      do_reset();
      tif.dir = 0; tif.tmr_load = 3; tif.tmr_pre = 0;
      tif.tmr_mode = TMR_MODE_PERIODIC;
      for (int n = 1; n <= 12; n++) begin
         cnt_exp_t e;
         e.val  = TW'(3 - ((n - 1) % 4));
         e.stop = ((n % 4) == 0);
         cq.push_back(e);
      end
      tif.ena = 1;
      step();
      while (cq.size() > 0) begin
         cnt_exp_t e;
         step();
         e = cq.pop_front();
         n_checks++;
         if (tif.tmr_val !== e.val || tif.stop_tmr !== e.stop) begin
            n_fail++;
            $display("FAIL periodic_down: tmr_val=%0d stop_tmr=%b, want %0d/%b", tif.tmr_val, tif.stop_tmr, e.val, e.stop);
         end
      end
      tif.ena = 0;
      step();
   endtask

   // Up, load 2, prescale 3, one-shot: 0,1,2 then held; a single stop.
   task automatic test_oneshot_up();
      int n_stop;
      do_reset();
      tif.dir = 1; tif.tmr_load = 2; tif.tmr_pre = 2; tif.oneshot = 1;
      for (int n = 1; n <= 14; n++) begin
         cnt_exp_t e;
         e.val  = (n < 4) ? TW'(0) : (n < 7) ? TW'(1) : TW'(2);
         e.stop = (n == 9);
         cq.push_back(e);
      end
      n_stop = 0;
      tif.ena = 1;
      step();
      for (int n = 1; cq.size() > 0; n++) begin
         cnt_exp_t e;
         step();
         e = cq.pop_front();
         if (tif.stop_tmr === 1'b1) n_stop++;
         n_checks++;
         if (tif.tmr_val !== e.val || tif.stop_tmr !== e.stop) begin
            n_fail++;
            $display("FAIL oneshot_up: cycle %0d tmr_val=%0d stop_tmr=%b, want %0d/%b", n, tif.tmr_val, tif.stop_tmr, e.val, e.stop);
         end
         if (n == 11) tif.ena = 0;
      end
      n_checks++;
      if (n_stop != 1) begin
         n_fail++;
         $display("FAIL oneshot_stop_count: got %0d pulses want 1", n_stop);
      end
   endtask

   // Up, load 9, channel A set at 2 and cleared at 6, complement enabled.
   task automatic test_pwm();
      do_reset();
      tif.tmr_mode = TMR_MODE_PWM; tif.dir = 1; tif.tmr_load = 9;
      tif.tmr_pre = 0; tif.cmp_en = 3'b001;
      tif.cmpa_t0 = 2; tif.cmpa_t1 = 6;
      tif.cmpb_t0 = 1; tif.cmpb_t1 = 3; tif.cmpc_t0 = 4; tif.cmpc_t1 = 5;
      tif.pwm_comp = 1; tif.tmr_dead = 2;
      repeat (5) step();
      for (int n = 1; n <= 25; n++) begin
         pwm_exp_t e;
         int  m;
         logic raw, gap_r, gap_f;
         m     = n % 10;
         raw   = (m >= 2) && (m <= 5);
         gap_r = DT && (m == 2 || m == 3);
         gap_f = DT && (m == 6 || m == 7);
         e.val   = TW'((n - 1) % 10);
         e.pwm   = {2'b00, raw & ~gap_r};
         e.pwm_n = {2'b11, ~raw & ~gap_f};
         e.evt   = {2'b00, (m == 2) || (m == 6)};
         pq.push_back(e);
      end
      tif.ena = 1;
      step();
      for (int n = 1; pq.size() > 0; n++) begin
         pwm_exp_t e;
         step();
         e = pq.pop_front();
         n_checks++;
         if (tif.tmr_val !== e.val || tif.pwm_out !== e.pwm ||
             tif.pwm_out_n !== e.pwm_n || tif.evt_cmp !== e.evt) begin
            n_fail++;
            $display("FAIL pwm: cycle %0d val/pwm/pwm_n/evt=%0d/%b/%b/%b want %0d/%b/%b/%b", n, tif.tmr_val, tif.pwm_out, tif.pwm_out_n, tif.evt_cmp, e.val, e.pwm, e.pwm_n, e.evt);
         end
      end
      tif.ena = 0;
      step();
   endtask

   // Pause freezes the count; resuming continues where it left off.
   task automatic test_pause();
      do_reset();
      tif.dir = 0; tif.tmr_load = 3; tif.tmr_pre = 0;
      for (int n = 0; n < 6; n++) begin
         cnt_exp_t e;
         e.val = 1; e.stop = 0;
         cq.push_back(e);
      end
      begin
         cnt_exp_t e;
         e.val = 1; e.stop = 0; cq.push_back(e);
         e.val = 0; e.stop = 1; cq.push_back(e);
         e.val = 3; e.stop = 0; cq.push_back(e);
      end
      tif.ena = 1;
      step();
      step();
      step();
      tif.pause = 1;
      for (int n = 1; cq.size() > 0; n++) begin
         cnt_exp_t e;
         step();
         e = cq.pop_front();
         if (n == 6) tif.pause = 0;
         n_checks++;
         if (tif.tmr_val !== e.val || tif.stop_tmr !== e.stop) begin
            n_fail++;
            $display("FAIL pause: cycle %0d tmr_val=%0d stop_tmr=%b, want %0d/%b", n, tif.tmr_val, tif.stop_tmr, e.val, e.stop);
         end
      end
      tif.ena = 0;
      step();
   endtask

   // ena drops exactly on the expiry tick: no stop, count holds, restart
   // from the load value once ena returns.
   task automatic test_ena_drop_on_expiry();
      do_reset();
      tif.dir = 0; tif.tmr_load = 3; tif.tmr_pre = 0;
      for (int n = 0; n < 4; n++) begin
         cnt_exp_t e;
         e.val = 0; e.stop = 0;
         cq.push_back(e);
      end
      begin
         cnt_exp_t e;
         e.val = 0; e.stop = 0; cq.push_back(e);
         e.val = 3; e.stop = 0; cq.push_back(e);
         e.val = 2; e.stop = 0; cq.push_back(e);
      end
      tif.ena = 1;
      step();
      repeat (3) step();
      tif.ena = 0;
      for (int n = 1; cq.size() > 0; n++) begin
         cnt_exp_t e;
         step();
         e = cq.pop_front();
         if (n == 4) tif.ena = 1;
         n_checks++;
         if (tif.tmr_val !== e.val || tif.stop_tmr !== e.stop) begin
            n_fail++;
            $display("FAIL ena_drop: cycle %0d tmr_val=%0d stop_tmr=%b, want %0d/%b", n, tif.tmr_val, tif.stop_tmr, e.val, e.stop);
         end
      end
   endtask

   // Watch 6 cycles after a pin change; a capture is expected on the 3rd
   // cycle only when capq holds a value.
   task automatic test_capture();
      int  budget;
      logic expect_cap;
      do_reset();
      tif.dir = 1; tif.tmr_load = 20; tif.tmr_pre = 7;
      tif.cpt_type = CPT_RISE;
      tif.ena = 1;
      budget = 0;
      while (tif.tmr_val !== TW'(5) && budget < 200) begin step(); budget++; end
      n_checks++;
      if (budget >= 200) begin n_fail++; $display("FAIL capture_wait5: tmr_val=%0d want 5 within 200 cycles", tif.tmr_val); end

      for (int phase = 0; phase < 5; phase++) begin
         case (phase)
            0: begin tif.cpt_in = 1; capq.push_back(TW'(5)); end
            1: begin tif.cpt_in = 0; end
            2: begin tif.cpt_type = CPT_OFF; tif.cpt_in = 1; end
            3: begin
                  budget = 0;
                  while (tif.tmr_val !== TW'(7) && budget < 200) begin step(); budget++; end
                  n_checks++;
                  if (budget >= 200) begin n_fail++; $display("FAIL capture_wait7: tmr_val=%0d want 7 within 200 cycles", tif.tmr_val); end
                  tif.pause = 1;
                  tif.cpt_type = CPT_FALL; tif.cpt_in = 0; capq.push_back(TW'(7));
               end
            default: begin tif.cpt_type = CPT_BOTH; tif.cpt_in = 1; capq.push_back(TW'(7)); end
         endcase
         expect_cap = (capq.size() > 0);
         for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 3 && expect_cap) begin
               logic [TW-1:0] want;
               want = capq.pop_front();
               n_checks++;
               if (tif.evt_cpt !== 1'b1 || tif.tmr_cpt !== want) begin
                  n_fail++;
                  $display("FAIL capture_phase%0d: evt_cpt=%b tmr_cpt=%0d want 1/%0d", phase, tif.evt_cpt, tif.tmr_cpt, want);
               end
            end else begin
               n_checks++;
               if (tif.evt_cpt !== 1'b0) begin
                  n_fail++;
                  $display("FAIL capture_phase%0d_noevt: cycle %0d evt_cpt=%b want 0", phase, k, tif.evt_cpt);
               end
            end
            if (phase >= 3) begin
               n_checks++;
               if (tif.tmr_val !== TW'(7)) begin
                  n_fail++;
                  $display("FAIL pause_frozen: tmr_val=%0d want 7", tif.tmr_val);
               end
            end
         end
         if (phase == 2) begin
            n_checks++;
            if (tif.tmr_cpt !== TW'(5)) begin
               n_fail++;
               $display("FAIL capture_off: tmr_cpt=%0d want 5", tif.tmr_cpt);
            end
         end
      end
   endtask

   // Reset while running with PWM active and a captured value present.
   task automatic test_reset_midrun();
      tif.pause = 0; tif.pwm_comp = 1; tif.cmp_en = 3'b111;
      tif.cmpa_t0 = 8; tif.cmpa_t1 = 15;
      repeat (20) step();
      reset = 1;
      step();
      n_checks++; if (tif.tmr_val !== '0) begin n_fail++; $display("FAIL midrun_tmr_val: got %0d want 0", tif.tmr_val); end
      n_checks++; if (tif.tmr_cpt !== '0) begin n_fail++; $display("FAIL midrun_tmr_cpt: got %0d want 0", tif.tmr_cpt); end
      n_checks++; if (tif.stop_tmr !== 1'b0) begin n_fail++; $display("FAIL midrun_stop_tmr: got %b want 0", tif.stop_tmr); end
      n_checks++; if (tif.evt_cmp !== 3'b000) begin n_fail++; $display("FAIL midrun_evt_cmp: got %b want 000", tif.evt_cmp); end
      n_checks++; if (tif.evt_cpt !== 1'b0) begin n_fail++; $display("FAIL midrun_evt_cpt: got %b want 0", tif.evt_cpt); end
      n_checks++; if (tif.pwm_out !== 3'b000) begin n_fail++; $display("FAIL midrun_pwm_out: got %b want 000", tif.pwm_out); end
      n_checks++; if (tif.pwm_out_n !== 3'b000) begin n_fail++; $display("FAIL midrun_pwm_out_n: got %b want 000", tif.pwm_out_n); end
      reset = 0;
      cfg_idle();
      step();
   endtask

   initial begin
      reset = 1;
      cfg_idle();
      test_reset();
      test_periodic_down();
      test_oneshot_up();
      test_pwm();
      test_pause();
      test_ena_drop_on_expiry();
      test_capture();
      test_reset_midrun();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
